// File: rtl/golay24_dec.sv
// Extended Golay {24,12,8} hard-decision decoder: syndrome error trapping over 23 cyclic
// shifts with x^16 / x^17 covering terms. Corrects up to 3 errors and detects 4.
`timescale 1ns/1ps
module golay24_dec #(
  parameter int pTAG_W = 1
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ival,
  input  logic [pTAG_W-1:0] itag,
  input  logic [23:0]       idat,
  output logic              ordy,
  output logic              oval,
  output logic [pTAG_W-1:0] otag,
  output logic [11:0]       odat,
  output logic [2:0]        onerr,
  output logic              odecfail
);

  localparam logic [11:0] GPOLY = 12'hC75;

  function automatic logic [10:0] mod_g(input logic [22:0] v);
    logic [22:0] r;
    r = v;
    for (int i = 22; i >= 11; i--) begin
      if (r[i]) r = r ^ (23'(GPOLY) << (i - 11));
    end
    return r[10:0];
  endfunction

  function automatic logic [4:0] wt23(input logic [22:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 23; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  localparam logic [10:0] S16 = mod_g(23'(1) << 16);
  localparam logic [10:0] S17 = mod_g(23'(1) << 17);

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

  state_t              state_q;
  logic [4:0]          t_q;
  logic                found_q;
  logic [4:0]          nc_q;
  logic                oval_q;
  logic [pTAG_W-1:0]   otag_q;
  logic [11:0]         odat_q;
  logic [2:0]          onerr_q;
  logic                odecfail_q;

  logic [22:0]         c_q;
  logic [10:0]         s_q;
  logic                p_q;
  logic [11:0]         raw_q;
  logic                b23_q;
  logic [pTAG_W-1:0]   tag_q;

  logic                hit;
  logic [22:0]         e;
  logic [10:0]         s16x, s17x;
  logic [22:0]         c_fix;
  logic [22:0]         c_d;
  logic [10:0]         s_d;
  logic [4:0]          nc_d;
  logic [4:0]          sum_d;

  // One trapping step on the current rotation; only the first matching pattern is applied.
  always_comb begin
    s16x  = s_q ^ S16;
    s17x  = s_q ^ S17;
    hit   = 1'b0;
    e     = '0;
    if (!found_q) begin
      if (wt23({12'd0, s_q}) <= 5'd3) begin
        hit = 1'b1;
        e   = {12'd0, s_q};
      end else if (wt23({12'd0, s16x}) <= 5'd2) begin
        hit = 1'b1;
        e   = (23'd1 << 16) | {12'd0, s16x};
      end else if (wt23({12'd0, s17x}) <= 5'd2) begin
        hit = 1'b1;
        e   = (23'd1 << 17) | {12'd0, s17x};
      end
    end
    nc_d  = wt23(e);
    c_fix = c_q ^ e;
    c_d   = {c_fix[21:0], c_fix[22]};
    s_d   = hit ? 11'd0 : ({s_q[9:0], 1'b0} ^ (s_q[10] ? GPOLY[10:0] : 11'd0));
    // Residual parity of the corrected 24-bit word adds one error when it is odd.
    sum_d = nc_q + 5'(p_q ^ nc_q[0]);
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= IDLE;
      t_q        <= '0;
      found_q    <= 1'b0;
      nc_q       <= '0;
      oval_q     <= 1'b0;
      otag_q     <= '0;
      odat_q     <= '0;
      onerr_q    <= '0;
      odecfail_q <= 1'b0;
    end else if (iclkena) begin
      oval_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ival) state_q <= LOAD;
        end
        LOAD: begin
          found_q <= 1'b0;
          nc_q    <= '0;
          t_q     <= '0;
          state_q <= SEARCH;
        end
        SEARCH: begin
          if (hit) begin
            found_q <= 1'b1;
            nc_q    <= nc_d;
          end
          if (t_q == 5'd22) state_q <= DONE;
          else              t_q     <= t_q + 5'd1;
        end
        DONE: begin
          oval_q <= 1'b1;
          otag_q <= tag_q;
          if (found_q && sum_d <= 5'd3) begin
            onerr_q    <= sum_d[2:0];
            odecfail_q <= 1'b0;
            odat_q     <= c_q[22:11];
          end else begin
            onerr_q    <= 3'd4;
            odecfail_q <= 1'b1;
            odat_q     <= raw_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      case (state_q)
        IDLE: begin
          if (ival) begin
            c_q   <= {idat[11:0], idat[22:12]};
            raw_q <= idat[11:0];
            b23_q <= idat[23];
            tag_q <= itag;
          end
        end
        LOAD: begin
          s_q <= mod_g(c_q);
          p_q <= ^{b23_q, c_q};
        end
        SEARCH: begin
          c_q <= c_d;
          s_q <= s_d;
        end
        default: ;
      endcase
    end
  end

  assign ordy     = (state_q == IDLE);
  assign oval     = oval_q;
  assign otag     = otag_q;
  assign odat     = odat_q;
  assign onerr    = onerr_q;
  assign odecfail = odecfail_q;

endmodule

// File: tb/tb_golay24_dec.sv
// Scoreboard bench for golay24_dec: driver pushes expected results, negedge monitor pops/compares.
`timescale 1ns/1ps
module tb_golay24_dec;

  logic        iclk = 1'b0;
  logic        ireset;
  logic        iclkena = 1'b1;
  logic        ival;
  logic [3:0]  itag;
  logic [23:0] idat;
  logic        ordy, oval, odecfail;
  logic [3:0]  otag;
  logic [11:0] odat;
  logic [2:0]  onerr;

  golay24_dec #(.pTAG_W(4)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .itag(itag),
    .idat(idat), .ordy(ordy), .oval(oval), .otag(otag), .odat(odat),
    .onerr(onerr), .odecfail(odecfail)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [11:0] dat;
    logic [2:0]  nerr;
    logic        fail;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   en_cnt = 0;
  logic en_last = 1'b0;
  logic ena_mode = 1'b0;
  int   ov_total = 0;

  always @(posedge iclk) begin
    if (iclkena) en_cnt <= en_cnt + 1;
    en_last <= iclkena;
  end

  always @(negedge iclk) iclkena = ena_mode ? ~iclkena : 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Systematic cyclic encoder in golay24_enc layout: [11:0] info, [22:12] check, [23] parity.
  function automatic logic [23:0] enc(input logic [11:0] m);
    logic [22:0] r;
    logic [22:0] cw;
    r = {m, 11'd0};
    for (int i = 22; i >= 11; i--) begin
      if (r[i]) r = r ^ (23'(12'hC75) << (i - 11));
    end
    cw = {m, r[10:0]};
    return {^cw, r[10:0], m};
  endfunction

  // Monitor: a new result is present when oval is high after an enabled edge.
  always @(negedge iclk) begin
    if (!ireset && oval && en_last) begin
      exp_t x;
      ov_total++;
      if (sbq.size() == 0) begin
        chk("unexpected_oval", 1, 0);
      end else begin
        x = sbq.pop_front();
        chk("odat", int'(odat), int'(x.dat));
        chk("onerr", int'(onerr), int'(x.nerr));
        chk("odecfail", int'(odecfail), int'(x.fail));
        chk("otag", int'(otag), int'(x.tag));
        chk("latency", en_cnt - x.acc, 25);
      end
    end
  end

  task automatic push_exp(input logic [11:0] d, input logic [2:0] n, input logic f,
                          input logic [3:0] tg);
    exp_t x;
    x.dat = d; x.nerr = n; x.fail = f; x.tag = tg; x.acc = en_cnt + 1;
    sbq.push_back(x);
  endtask

  task automatic send(input logic [23:0] w, input logic [3:0] tg, input logic [11:0] d,
                      input logic [2:0] n, input logic f, input bit push);
    int cnt;
    cnt = 0;
    @(negedge iclk); #1;
    ival = 1'b1; idat = w; itag = tg;
    while (!(ordy && iclkena)) begin
      @(negedge iclk); #1;
      cnt++;
      if (cnt > 400) begin
        chk("send_timeout", cnt, 0);
        ival = 1'b0;
        return;
      end
    end
    if (push) push_exp(d, n, f, tg);
    @(negedge iclk);
    ival = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (sbq.size() != 0 && cnt < 3000) begin
      @(negedge iclk);
      cnt++;
    end
    chk("drain_pending", sbq.size(), 0);
  endtask

  // Expected result for codeword of m with the flips in mask (distinct bits, weight 0..4).
  task automatic send_flip(input logic [11:0] m, input logic [23:0] mask, input logic [3:0] tg);
    logic [23:0] w;
    int          k;
    w = enc(m) ^ mask;
    k = $countones(mask);
    if (k <= 3) send(w, tg, m, 3'(k), 1'b0, 1'b1);
    else        send(w, tg, w[11:0], 3'd4, 1'b1, 1'b1);
  endtask

  initial begin
    int          acc;
    int          ovb;
    logic [23:0] mask;
    logic [11:0] m;
    int          k;

    ireset = 1'b1; ival = 1'b0; idat = '0; itag = '0;
    repeat (3) @(negedge iclk);
    chk("rst_ordy", int'(ordy), 1);
    chk("rst_oval", int'(oval), 0);
    chk("rst_odat", int'(odat), 0);
    chk("rst_onerr", int'(onerr), 0);
    chk("rst_odecfail", int'(odecfail), 0);
    chk("rst_otag", int'(otag), 0);
    ireset = 1'b0;

    send_flip(12'hA5C, 24'h000000, 4'h1);
    send_flip(12'hA5C, 24'h100801, 4'h2);
    send_flip(12'hA5C, 24'h000444, 4'h3);
    send_flip(12'h000, 24'h800000, 4'h4);
    send_flip(12'h000, 24'h800020, 4'h5);
    send_flip(12'hFFF, 24'h002222, 4'h6);
    send_flip(12'h3C7, 24'h801100, 4'h7);
    send_flip(12'h3C7, 24'h060000, 4'h8);
    send_flip(12'h801, 24'h400000, 4'h9);
    drain();

    // Reset during SEARCH t=10 must abort without a result.
    send(enc(12'h5A5) ^ 24'h000003, 4'hA, 12'h5A5, 3'd2, 1'b0, 1'b0);
    repeat (11) @(negedge iclk);
    #1 ireset = 1'b1;
    #1;
    chk("abort_ordy", int'(ordy), 1);
    chk("abort_oval", int'(oval), 0);
    @(negedge iclk);
    ireset = 1'b0;
    ovb = ov_total;
    repeat (40) @(negedge iclk);
    chk("abort_no_oval", ov_total - ovb, 0);

    // ival held high: only words seen while idle are accepted.
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iclk); #1;
      m = 12'h100 + 12'(i * 37);
      ival = 1'b1; idat = enc(m) ^ 24'h000010; itag = 4'(i);
      if (ordy && iclkena) begin
        push_exp(m, 3'd1, 1'b0, 4'(i));
        acc++;
      end
    end
    @(negedge iclk);
    ival = 1'b0;
    chk("hold_accepts", acc, 2);
    drain();

    // 50% clock enable: same results, latency counted in enabled edges.
    ena_mode = 1'b1;
    send_flip(12'hA5C, 24'h100801, 4'hB);
    send_flip(12'hFFF, 24'h002222, 4'hC);
    send_flip(12'h000, 24'h800020, 4'hD);
    drain();
    ena_mode = 1'b0;

    for (int i = 0; i < 150; i++) begin
      m = 12'($urandom_range(4095, 0));
      k = $urandom_range(4, 0);
      mask = '0;
      while ($countones(mask) < k) mask = mask | (24'd1 << $urandom_range(23, 0));
      send_flip(m, mask, 4'($urandom_range(15, 0)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
